// File: rtl/morse_msg_scheduler.sv
// Letter FIFO feeding a Morse dot/dash serialiser with symbol-rate ticks and inter-letter gaps.
// Optional feature: define MORSE_ABORT_EN to add an Abort input that flushes and idles the block.
module morse_msg_scheduler #(
  parameter int CLOCK_FREQUENCY = 500,
  parameter int DEPTH           = 4,
  parameter int GAP_SYMBOLS     = 3
) (
  input  logic                     ClockIn,
  input  logic                     Reset,
  input  logic [2:0]               LetterIn,
  input  logic                     LetterWr,
  input  logic                     Start,
`ifdef MORSE_ABORT_EN
  input  logic                     Abort,
`endif
  output logic                     DotDashOut,
  output logic                     Busy,
  output logic                     Done,
  output logic                     Full,
  output logic                     Empty,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int TICKS = CLOCK_FREQUENCY / 2;
  localparam int TW    = $clog2(TICKS);
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int GW    = (GAP_SYMBOLS > 1) ? $clog2(GAP_SYMBOLS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

  state_t          state_reg, state_next;
  logic [12:0]     shreg_reg, shreg_next;
  logic [3:0]      symcnt_reg, symcnt_next;
  logic [TW-1:0]   tick_reg, tick_next;
  logic [GW-1:0]   gapcnt_reg, gapcnt_next;
  logic [CW-1:0]   count_reg, count_next;
  logic [AW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]   rd_ptr_reg, rd_ptr_next;
  logic            dot_reg, dot_next;
  logic            done_reg, done_next;
  logic            push, pop, flush, expired, full_w, empty_w, abort;
  logic [2:0]      mem [DEPTH];

`ifdef MORSE_ABORT_EN
  assign abort = Abort;
`else
  assign abort = 1'b0;
`endif

  function automatic logic [12:0] pattern(input logic [2:0] code);
    case (code)
      3'd0:    pattern = 13'b0101110000000;
      3'd1:    pattern = 13'b0111010101000;
      3'd2:    pattern = 13'b0111010111010;
      3'd3:    pattern = 13'b0111010100000;
      3'd4:    pattern = 13'b0100000000000;
      3'd5:    pattern = 13'b0101011101000;
      3'd6:    pattern = 13'b0111011101000;
      default: pattern = 13'b0101010100000;
    endcase
  endfunction

  assign full_w  = (count_reg == CW'(DEPTH));
  assign empty_w = (count_reg == '0);
  assign expired = (tick_reg == '0);

  always_comb begin
    state_next  = state_reg;
    shreg_next  = shreg_reg;
    symcnt_next = symcnt_reg;
    tick_next   = tick_reg;
    gapcnt_next = gapcnt_reg;
    done_next   = 1'b0;
    pop         = 1'b0;
    flush       = 1'b0;
    push        = LetterWr && !full_w;
    case (state_reg)
      IDLE: begin
        if (Start && !empty_w) state_next = LOAD;
      end
      LOAD: begin
        pop         = 1'b1;
        shreg_next  = pattern(mem[rd_ptr_reg]);
        symcnt_next = 4'd12;
        tick_next   = TW'(TICKS - 1);
        state_next  = SHIFT;
      end
      SHIFT: begin
        if (expired) begin
          tick_next = TW'(TICKS - 1);
          if (symcnt_reg == 4'd0) begin
            state_next  = GAP;
            gapcnt_next = GW'(GAP_SYMBOLS - 1);
          end else begin
            shreg_next  = {shreg_reg[11:0], 1'b0};
            symcnt_next = symcnt_reg - 4'd1;
          end
        end else begin
          tick_next = tick_reg - TW'(1);
        end
      end
      GAP: begin
        if (expired) begin
          tick_next = TW'(TICKS - 1);
          if (gapcnt_reg != '0) begin
            gapcnt_next = gapcnt_reg - GW'(1);
          end else if (!empty_w) begin
            state_next = LOAD;
          end else begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end else begin
          tick_next = tick_reg - TW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
    // Output lags state by one cycle so each symbol holds for exactly TICKS cycles.
    dot_next = (state_reg == SHIFT) ? shreg_reg[12] : 1'b0;
    if (abort) begin
      state_next = IDLE;
      done_next  = 1'b0;
      dot_next   = 1'b0;
      push       = 1'b0;
      pop        = 1'b0;
      flush      = 1'b1;
    end
    wr_ptr_next = flush ? '0 : (push ? wr_ptr_reg + AW'(1) : wr_ptr_reg);
    rd_ptr_next = flush ? '0 : (pop  ? rd_ptr_reg + AW'(1) : rd_ptr_reg);
    if (flush)              count_next = '0;
    else if (push && !pop)  count_next = count_reg + CW'(1);
    else if (pop && !push)  count_next = count_reg - CW'(1);
    else                    count_next = count_reg;
  end

  always_ff @(posedge ClockIn or posedge Reset) begin
    if (Reset) begin
      state_reg  <= IDLE;
      shreg_reg  <= '0;
      symcnt_reg <= '0;
      tick_reg   <= '0;
      gapcnt_reg <= '0;
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      dot_reg    <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      shreg_reg  <= shreg_next;
      symcnt_reg <= symcnt_next;
      tick_reg   <= tick_next;
      gapcnt_reg <= gapcnt_next;
      count_reg  <= count_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      dot_reg    <= dot_next;
      done_reg   <= done_next;
    end
  end

  always_ff @(posedge ClockIn) begin
    if (push) mem[wr_ptr_reg] <= LetterIn;
  end

  assign DotDashOut = dot_reg;
  assign Busy       = (state_reg != IDLE);
  assign Done       = done_reg;
  assign Full       = full_w;
  assign Empty      = empty_w;
  assign Count      = count_reg;

endmodule

// File: tb/tb_morse_msg_scheduler.sv
// Bench for morse_msg_scheduler: letter-timeline reference model plus directed literal checks.
// Abort scenarios are exercised when MORSE_ABORT_EN is defined.
module tb_morse_msg_scheduler;

  localparam int CF     = 8;
  localparam int DEPTH  = 4;
  localparam int GAPS   = 3;
  localparam int T      = CF / 2;
  localparam int LETTER = 1 + 13 * T + GAPS * T;

  logic       ClockIn = 1'b0;
  logic       Reset;
  logic [2:0] LetterIn;
  logic       LetterWr;
  logic       Start;
`ifdef MORSE_ABORT_EN
  logic       Abort;
`endif
  logic       DotDashOut, Busy, Done, Full, Empty;
  logic [2:0] Count;

  int checks = 0;
  int errors = 0;

  // Model: pending letters, whether a letter slot is running, and cycles since its LOAD edge.
  int q[$];
  bit m_busy = 0;
  int m_k    = 0;
  int m_cur  = 0;
  bit m_done = 0;

  morse_msg_scheduler #(.CLOCK_FREQUENCY(CF), .DEPTH(DEPTH), .GAP_SYMBOLS(GAPS)) dut (
    .ClockIn(ClockIn), .Reset(Reset), .LetterIn(LetterIn), .LetterWr(LetterWr), .Start(Start),
`ifdef MORSE_ABORT_EN
    .Abort(Abort),
`endif
    .DotDashOut(DotDashOut), .Busy(Busy), .Done(Done), .Full(Full), .Empty(Empty), .Count(Count)
  );

  always #5 ClockIn = ~ClockIn;

  function automatic logic [12:0] pat(input int c);
    case (c)
      0: return 13'b0101110000000;
      1: return 13'b0111010101000;
      2: return 13'b0111010111010;
      3: return 13'b0111010100000;
      4: return 13'b0100000000000;
      5: return 13'b0101011101000;
      6: return 13'b0111011101000;
      default: return 13'b0101010100000;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_dot();
    logic [12:0] p;
    if (m_busy && m_k >= 2 && m_k <= 1 + 13 * T) begin
      p = pat(m_cur);
      return int'(p[12 - (m_k - 2) / T]);
    end
    return 0;
  endfunction

  task automatic model_edge(input bit wr, input int code, input bit st, input bit ab);
    int pre;
    pre = q.size();
    m_done = 0;
    if (ab) begin
      q.delete();
      m_busy = 0;
      return;
    end
    if (m_busy && m_k == 0) m_cur = q.pop_front();
    if (wr && pre < DEPTH) q.push_back(code);
    if (!m_busy) begin
      if (st && pre != 0) begin
        m_busy = 1;
        m_k = 0;
      end
    end else if (m_k == LETTER - 1) begin
      if (pre != 0) m_k = 0;
      else begin
        m_busy = 0;
        m_done = 1;
      end
    end else begin
      m_k++;
    end
  endtask

  task automatic compare_all();
    chk("dot",   int'(DotDashOut), exp_dot());
    chk("busy",  int'(Busy),  int'(m_busy));
    chk("done",  int'(Done),  int'(m_done));
    chk("count", int'(Count), q.size());
    chk("full",  int'(Full),  int'(q.size() == DEPTH));
    chk("empty", int'(Empty), int'(q.size() == 0));
  endtask

  // Drive inputs away from the edge, advance one clock, update the model, compare.
  task automatic step(input bit wr, input int code, input bit st, input bit ab);
    LetterWr = wr;
    LetterIn = 3'(code);
    Start    = st;
`ifdef MORSE_ABORT_EN
    Abort    = ab;
`endif
    @(posedge ClockIn);
    model_edge(wr, code, st, ab);
    #1;
    compare_all();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_dot"},   int'(DotDashOut), 0);
    chk({tag, "_busy"},  int'(Busy), 0);
    chk({tag, "_done"},  int'(Done), 0);
    chk({tag, "_empty"}, int'(Empty), 1);
    chk({tag, "_full"},  int'(Full), 0);
    chk({tag, "_count"}, int'(Count), 0);
  endtask

  task automatic reset_mid();
    #1;
    Reset = 1'b1;
    #1;
    check_reset_values("async_rst");
    @(posedge ClockIn);
    #1;
    Reset = 1'b0;
    q.delete();
    m_busy = 0;
    m_done = 0;
  endtask

  initial begin
    int first_done, ndone, d5, d6, d9, d10, b65;
    Reset = 1'b1; LetterIn = '0; LetterWr = 1'b0; Start = 1'b0;
`ifdef MORSE_ABORT_EN
    Abort = 1'b0;
`endif
    #2;
    check_reset_values("por");
    @(posedge ClockIn);
    #1;
    Reset = 1'b0;

    // Single E: Start edge is edge 0, Done expected after edge 65.
    step(1, 4, 0, 0);
    step(0, 0, 1, 0);
    first_done = -1; d5 = -1; d6 = -1; d9 = -1; d10 = -1;
    for (int n = 1; n <= 70; n++) begin
      step(0, 0, 0, 0);
      if (Done && first_done < 0) first_done = n;
      if (n == 5)  d5  = int'(DotDashOut);
      if (n == 6)  d6  = int'(DotDashOut);
      if (n == 9)  d9  = int'(DotDashOut);
      if (n == 10) d10 = int'(DotDashOut);
    end
    chk("e_done_cycle", first_done, 65);
    chk("e_dot_k5", d5, 0);
    chk("e_dot_k6", d6, 1);
    chk("e_dot_k9", d9, 1);
    chk("e_dot_k10", d10, 0);
    $display("letter E sent, done after edge %0d", first_done);

    // Start while empty, with a same-cycle write: ignored.
    step(1, 5, 1, 0);
    chk("empty_start_busy", int'(Busy), 0);
    chk("empty_start_count", int'(Count), 1);
    step(0, 0, 1, 0);
    for (int n = 0; n < LETTER + 2; n++) step(0, 0, 0, 0);
    $display("start-while-empty ignored, queued F then sent");

    // A then B back to back, with Starts while busy.
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(0, 0, 1, 0);
    ndone = 0; first_done = -1; b65 = -1;
    for (int n = 1; n <= 2 * LETTER + 5; n++) begin
      step(0, 0, (n == 20 || n == 80), 0);
      if (Done) begin
        ndone++;
        if (first_done < 0) first_done = n;
      end
      if (n == 65) b65 = int'(Busy);
    end
    chk("ab_done_pulses", ndone, 1);
    chk("ab_done_cycle", first_done, 130);
    chk("ab_busy_at_65", b65, 1);
    $display("letters A,B sent, %0d done pulse(s)", ndone);

    // Five writes with no Start: fifth dropped; drain sends the first four.
    for (int i = 0; i < 5; i++) step(1, i + 2, 0, 0);
    chk("five_count", int'(Count), 4);
    chk("five_full", int'(Full), 1);
    step(0, 0, 1, 0);
    ndone = 0;
    for (int n = 0; n < 4 * LETTER + 3; n++) begin
      step(0, 0, 0, 0);
      if (Done) ndone++;
    end
    chk("five_done_pulses", ndone, 1);
    chk("five_empty", int'(Empty), 1);
    $display("fifo overflow drop and drain complete");

    // Reset in the middle of a transmission.
    step(1, 6, 0, 0);
    step(1, 7, 0, 0);
    step(0, 0, 1, 0);
    for (int n = 0; n < 30; n++) step(0, 0, 0, 0);
    reset_mid();
    check_reset_values("post_rst");
    $display("async reset mid-transmission");

`ifdef MORSE_ABORT_EN
    step(1, 1, 0, 0);
    step(1, 2, 0, 0);
    step(1, 3, 0, 0);
    step(0, 0, 1, 0);
    for (int n = 0; n < 10; n++) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("abort_busy", int'(Busy), 0);
    chk("abort_count", int'(Count), 0);
    chk("abort_done", int'(Done), 0);
    step(0, 0, 0, 0);
    chk("abort_done_next", int'(Done), 0);
    $display("abort in SHIFT with two queued");
`endif

    // Randomized traffic checked cycle by cycle against the model.
    for (int i = 0; i < 4000; i++) begin
      bit wr, st, ab;
      wr = ($urandom_range(0, 39) == 0);
      st = ($urandom_range(0, 15) == 0);
`ifdef MORSE_ABORT_EN
      ab = ($urandom_range(0, 599) == 0);
`else
      ab = 1'b0;
`endif
      step(wr, int'($urandom_range(0, 7)), st, ab);
      if ($urandom_range(0, 1499) == 0) reset_mid();
    end
    $display("random phase complete");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
